// File: rtl/stream_fifo_pkg.sv
// Shared constants and helpers for the block-RAM stream FIFO.
package stream_fifo_pkg;

  localparam int STAGE_DEPTH = 2;

  function automatic int lvl_w(input int addr_w);
    return addr_w + 2;
  endfunction

  // Pointer increment with wrap at 2**addr_w.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple-dual-port RAM: one write port, one read port with registered output
// (1-cycle read latency). Storage is not reset.
module sdp_ram #(
  parameter int WIDTH  = 72,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/stream_bram_fifo.sv
// Valid/ready stream FIFO over sdp_ram with a 2-entry prefetch stage, occupancy
// level and almost-full/empty flags. STREAM_FIFO_PEAK_EN adds peak-level tracking.
module stream_bram_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH     = 72,
  parameter int ADDR_W    = 9,
  parameter int AFULL_TH  = 480,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH-1:0]  ss_data,
  input  logic              ss_valid,
  output logic              ss_ready,
  output logic [WIDTH-1:0]  ms_data,
  output logic              ms_valid,
  input  logic              ms_ready,
  output logic [ADDR_W+1:0] level,
  output logic              almost_full,
  output logic              almost_empty
`ifdef STREAM_FIFO_PEAK_EN
  ,
  input  logic              peak_clr,
  output logic [ADDR_W+1:0] peak_level
`endif
);

  localparam int LW = lvl_w(ADDR_W);
  localparam logic [ADDR_W:0] RAM_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic              r_resetn_q;
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_inflight;
  logic [1:0]        r_stage_cnt;
  logic [WIDTH-1:0]  r_stage0, r_stage1;
  logic [LW-1:0]     r_level;
  logic              r_afull, r_aempty;

  logic              w_wr, w_rd, w_dlv;
  logic [2:0]        w_occ;
  logic [1:0]        w_arr_idx;
  logic [LW-1:0]     w_level_nxt;
  logic [WIDTH-1:0]  w_rdata;

  assign ss_ready = r_resetn_q && (r_ram_cnt != RAM_FULL);
  assign ms_valid = (r_stage_cnt != 2'd0);
  assign ms_data  = r_stage0;
  assign w_wr     = ss_valid && ss_ready;
  assign w_dlv    = ms_valid && ms_ready;

  // Slot accounting includes this cycle's delivery so the stage never bubbles
  // while streaming.
  assign w_occ = {1'b0, r_stage_cnt} + {2'b0, r_inflight} - {2'b0, w_dlv};
  assign w_rd  = (r_ram_cnt != '0) && (w_occ < 3'(STAGE_DEPTH));
  assign w_arr_idx = r_stage_cnt - {1'b0, w_dlv};

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_dlv)      w_level_nxt = r_level + LW'(1);
    else if (!w_wr && w_dlv) w_level_nxt = r_level - LW'(1);
  end

  sdp_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
    .i_clk   (clk),
    .i_wr_en (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (ss_data),
    .i_rd_en (w_rd),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_resetn_q  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_ram_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_stage_cnt <= 2'd0;
      r_level     <= '0;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
    end else begin
      r_resetn_q <= 1'b1;
      if (w_wr) r_wptr <= ADDR_W'(ptr_inc(32'(r_wptr), ADDR_W));
      if (w_rd) r_rptr <= ADDR_W'(ptr_inc(32'(r_rptr), ADDR_W));
      case ({w_wr, w_rd})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      r_inflight  <= w_rd;
      r_stage_cnt <= r_stage_cnt + {1'b0, r_inflight} - {1'b0, w_dlv};
      r_level     <= w_level_nxt;
      r_afull     <= (w_level_nxt >= LW'(AFULL_TH));
      r_aempty    <= (w_level_nxt <= LW'(AEMPTY_TH));
    end
  end

  // Arrivals land behind the head, so the presented word never moves under backpressure.
  always_ff @(posedge clk) begin
    if (w_dlv) r_stage0 <= r_stage1;
    if (r_inflight) begin
      if (w_arr_idx == 2'd0) r_stage0 <= w_rdata;
      else                   r_stage1 <= w_rdata;
    end
  end

  assign level        = r_level;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

`ifdef STREAM_FIFO_PEAK_EN
  logic [LW-1:0] r_peak;

  always_ff @(posedge clk) begin
    if (!resetn)                    r_peak <= '0;
    else if (peak_clr)              r_peak <= w_level_nxt;
    else if (w_level_nxt > r_peak)  r_peak <= w_level_nxt;
  end

  assign peak_level = r_peak;
`endif

endmodule
